// File: rtl/cpu_run_ctrl.sv
// Run controller around the mips core: stretches the core reset, counts RUN
// cycles and detects program end (halt word, stable PC or cycle budget).
module cpu_run_ctrl #(
  parameter int          PC_W         = 32,
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 1,
  parameter int          MAX_CYCLES   = 10000,
  parameter logic [31:0] HALT_WORD    = 32'h1000ffff,
  parameter int          HALT_REPEAT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  output logic             cpu_reset,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             timeout,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam int SAME_W = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {HOLD, RUN, DONE, TIMEOUT} state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [SAME_W-1:0]  same_cnt, same_cnt_nxt, same_run;
  logic [PC_W-1:0]    prev_pc, prev_pc_nxt, halt_pc_nxt;
  logic               prev_valid, prev_valid_nxt;
  logic [CNT_W-1:0]   cycle_cnt_nxt, cycle_inc;
  logic               cpu_reset_nxt, running_nxt, done_nxt, timeout_nxt;
  logic               halt_hit, budget_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      same_cnt   <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      cpu_reset  <= 1'b1;
      running    <= 1'b0;
      cycle_cnt  <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      halt_pc    <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      same_cnt   <= same_cnt_nxt;
      prev_pc    <= prev_pc_nxt;
      prev_valid <= prev_valid_nxt;
      cpu_reset  <= cpu_reset_nxt;
      running    <= running_nxt;
      cycle_cnt  <= cycle_cnt_nxt;
      done       <= done_nxt;
      timeout    <= timeout_nxt;
      halt_pc    <= halt_pc_nxt;
    end
  end

  always_comb begin
    cycle_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
    if (!prev_valid || pc != prev_pc) begin
      same_run = '0;
    end else if (same_cnt == SAME_W'(HALT_REPEAT)) begin
      same_run = same_cnt;
    end else begin
      same_run = same_cnt + 1'b1;
    end
    halt_hit   = (instr == HALT_WORD) ||
                 ((HALT_REPEAT != 0) && (same_run == SAME_W'(HALT_REPEAT)));
    // A halt on the same edge as budget exhaustion takes priority.
    budget_hit = (MAX_CYCLES != 0) && !halt_hit &&
                 (cycle_inc == CNT_W'(MAX_CYCLES));

    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    same_cnt_nxt   = same_cnt;
    prev_pc_nxt    = prev_pc;
    prev_valid_nxt = prev_valid;
    cpu_reset_nxt  = cpu_reset;
    running_nxt    = running;
    cycle_cnt_nxt  = cycle_cnt;
    done_nxt       = done;
    timeout_nxt    = timeout;
    halt_pc_nxt    = halt_pc;

    case (state)
      HOLD: begin
        hold_cnt_nxt = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
          state_nxt     = RUN;
          cpu_reset_nxt = 1'b0;
          running_nxt   = 1'b1;
        end
      end
      RUN: begin
        cycle_cnt_nxt  = cycle_inc;
        prev_pc_nxt    = pc;
        prev_valid_nxt = 1'b1;
        same_cnt_nxt   = same_run;
        if (halt_hit) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          running_nxt = 1'b0;
          halt_pc_nxt = pc;
        end else if (budget_hit) begin
          state_nxt   = TIMEOUT;
          timeout_nxt = 1'b1;
          running_nxt = 1'b0;
          halt_pc_nxt = pc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances (defaults, RESET_CYCLES=3,
// MAX_CYCLES=8) share one stimulus stream; expectations go through a queue.
module tb_cpu_run_ctrl;

  localparam logic [31:0] HALT = 32'h1000ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;

  logic        a_cpu_reset, a_running, a_done, a_timeout;
  logic [31:0] a_cycle_cnt, a_halt_pc;
  logic        b_cpu_reset, b_running, b_done, b_timeout;
  logic [31:0] b_cycle_cnt, b_halt_pc;
  logic        c_cpu_reset, c_running, c_done, c_timeout;
  logic [31:0] c_cycle_cnt, c_halt_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] value;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_run_ctrl dut_a (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr),
    .cpu_reset(a_cpu_reset), .running(a_running), .cycle_cnt(a_cycle_cnt),
    .done(a_done), .timeout(a_timeout), .halt_pc(a_halt_pc)
  );

  cpu_run_ctrl #(.RESET_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr),
    .cpu_reset(b_cpu_reset), .running(b_running), .cycle_cnt(b_cycle_cnt),
    .done(b_done), .timeout(b_timeout), .halt_pc(b_halt_pc)
  );

  cpu_run_ctrl #(.MAX_CYCLES(8)) dut_c (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr),
    .cpu_reset(c_cpu_reset), .running(c_running), .cycle_cnt(c_cycle_cnt),
    .done(c_done), .timeout(c_timeout), .halt_pc(c_halt_pc)
  );

  // Selector = instance*8 + field (0 cpu_reset, 1 running, 2 cycle_cnt,
  // 3 done, 4 timeout, 5 halt_pc).
  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0:  return 64'(a_cpu_reset);
      1:  return 64'(a_running);
      2:  return 64'(a_cycle_cnt);
      3:  return 64'(a_done);
      4:  return 64'(a_timeout);
      5:  return 64'(a_halt_pc);
      8:  return 64'(b_cpu_reset);
      9:  return 64'(b_running);
      10: return 64'(b_cycle_cnt);
      11: return 64'(b_done);
      12: return 64'(b_timeout);
      13: return 64'(b_halt_pc);
      16: return 64'(c_cpu_reset);
      17: return 64'(c_running);
      18: return 64'(c_cycle_cnt);
      19: return 64'(c_done);
      20: return 64'(c_timeout);
      21: return 64'(c_halt_pc);
      default: return '1;
    endcase
  endfunction

  task automatic push(input string tag, input int inst, input int field,
                      input logic [63:0] value);
    exp_t e;
    e.tag   = tag;
    e.sel   = inst * 8 + field;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic push_reset_values(input int inst);
    push("rst_cpu_reset", inst, 0, 64'd1);
    push("rst_running",   inst, 1, 64'd0);
    push("rst_cycle_cnt", inst, 2, 64'd0);
    push("rst_done",      inst, 3, 64'd0);
    push("rst_timeout",   inst, 4, 64'd0);
    push("rst_halt_pc",   inst, 5, 64'd0);
  endtask

  task automatic check_output();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.value)
      else begin
        failures++;
        $error("[TB] FAIL %s (sel %0d) observed=%0h expected=%0h",
               e.tag, e.sel, obs, e.value);
      end
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic [31:0] p,
                                input logic [31:0] i);
    reset = rst;
    pc    = p;
    instr = i;
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Reset edge followed by the release edge that enters RUN (RESET_CYCLES=1).
  task automatic start_run();
    push_reset_values(0);
    push_reset_values(2);
    apply_stimulus(1'b1, 32'h0, 32'h0);
    push("go_cpu_reset", 0, 0, 64'd0);
    push("go_running",   0, 1, 64'd1);
    push("go_cpu_reset", 2, 0, 64'd0);
    push("go_running",   2, 1, 64'd1);
    apply_stimulus(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    pc    = '0;
    instr = '0;

    // Reset values, release, and reset stretching on both instances.
    push_reset_values(0);
    push_reset_values(1);
    push_reset_values(2);
    apply_stimulus(1'b1, 32'h0, 32'h0);
    push("e1_cpu_reset", 0, 0, 64'd0);
    push("e1_running",   0, 1, 64'd1);
    push("e1_cycle_cnt", 0, 2, 64'd0);
    push("b_e1_cpu_reset", 1, 0, 64'd1);
    push("b_e1_running",   1, 1, 64'd0);
    apply_stimulus(1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      push("inc_cycle_cnt", 0, 2, 64'(k));
      push("inc_running",   0, 1, 64'd1);
      push("inc_done",      0, 3, 64'd0);
      push("b_cpu_reset",   1, 0, (k < 2) ? 64'd1 : 64'd0);
      push("b_cycle_cnt",   1, 2, (k <= 2) ? 64'd0 : 64'(k - 2));
      apply_stimulus(1'b0, 32'h3000 + 32'(4 * (k - 1)), 32'h0);
    end

    // Halt word on the 5th RUN edge, then frozen results.
    start_run();
    for (int k = 1; k <= 5; k++) begin
      push("hw_done", 0, 3, (k == 5) ? 64'd1 : 64'd0);
      if (k == 5) begin
        push("hw_halt_pc",   0, 5, 64'h3010);
        push("hw_cycle_cnt", 0, 2, 64'd5);
        push("hw_running",   0, 1, 64'd0);
        push("hw_timeout",   0, 4, 64'd0);
      end
      apply_stimulus(1'b0, 32'h3000 + 32'(4 * (k - 1)), (k == 5) ? HALT : 32'h0);
    end
    for (int k = 0; k < 20; k++) begin
      push("frz_done",      0, 3, 64'd1);
      push("frz_halt_pc",   0, 5, 64'h3010);
      push("frz_cycle_cnt", 0, 2, 64'd5);
      push("frz_cpu_reset", 0, 0, 64'd0);
      apply_stimulus(1'b0, $urandom, $urandom);
    end

    // Stable PC from the 3rd RUN edge fires on the 7th.
    start_run();
    for (int k = 1; k <= 7; k++) begin
      push("spc_done", 0, 3, (k == 7) ? 64'd1 : 64'd0);
      if (k == 7) begin
        push("spc_cycle_cnt", 0, 2, 64'd7);
        push("spc_halt_pc",   0, 5, 64'h3008);
      end
      apply_stimulus(1'b0, (k == 1) ? 32'h3000 : (k == 2) ? 32'h3004 : 32'h3008,
                     32'h0);
    end

    // Budget of 8 RUN cycles runs out.
    start_run();
    for (int k = 1; k <= 8; k++) begin
      push("to_timeout", 2, 4, (k == 8) ? 64'd1 : 64'd0);
      push("to_done",    2, 3, 64'd0);
      if (k == 8) begin
        push("to_cycle_cnt", 2, 2, 64'd8);
        push("to_running",   2, 1, 64'd0);
        push("to_halt_pc",   2, 5, 64'h301c);
      end
      apply_stimulus(1'b0, 32'h3000 + 32'(4 * (k - 1)), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      push("to_frz_timeout",   2, 4, 64'd1);
      push("to_frz_cycle_cnt", 2, 2, 64'd8);
      apply_stimulus(1'b0, 32'h4000 + 32'(4 * k), 32'h0);
    end

    // Halt word coincides with budget exhaustion: halt wins.
    start_run();
    for (int k = 1; k <= 8; k++) begin
      push("tie_done",    2, 3, (k == 8) ? 64'd1 : 64'd0);
      push("tie_timeout", 2, 4, 64'd0);
      if (k == 8) push("tie_cycle_cnt", 2, 2, 64'd8);
      apply_stimulus(1'b0, 32'h3000 + 32'(4 * (k - 1)), (k == 8) ? HALT : 32'h0);
    end

    // Reset mid-RUN restores everything and the HOLD sequence restarts.
    start_run();
    for (int k = 1; k <= 5; k++) begin
      push("mid_cycle_cnt", 0, 2, 64'(k));
      apply_stimulus(1'b0, 32'h3000 + 32'(4 * (k - 1)), 32'h0);
    end
    push_reset_values(0);
    push_reset_values(1);
    push_reset_values(2);
    apply_stimulus(1'b1, 32'h3014, 32'h0);
    push("re_cpu_reset",   0, 0, 64'd0);
    push("re_running",     0, 1, 64'd1);
    push("b_re_cpu_reset", 1, 0, 64'd1);
    apply_stimulus(1'b0, 32'h0, 32'h0);
    push("re_cycle_cnt", 0, 2, 64'd1);
    apply_stimulus(1'b0, 32'h3000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
